// File: rtl/mmuart_pkg.sv
// Shared mmuart definitions: receiver FSM states, oversampling constants and the
// majority voter used by the RX sampler.
package mmuart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;
  localparam logic [3:0] COUNT_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST     = 3'(DATA_BITS - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mmuart_baud_tick.sv
// Oversample tick generator: one-cycle tick every `divisor` clocks (0 acts as 65536).
// No backpressure; a new divisor is picked up at the next reload.
module mmuart_baud_tick (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = (cnt == 16'd0);

  // divisor 0 reloads 0xFFFF, giving the 65536-cycle period for free
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= 16'd0;
    end else if (tick) begin
      cnt <= divisor - 16'd1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/mmuart_rx.sv
// 8N1 UART receiver, 16x oversampled with 3-sample vote; byte lands ~9.5 bit times after
// the start edge. Valid/ack holding register: an unacked byte is overwritten and flagged.
module mmuart_rx
  import mmuart_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx,
  input  logic [15:0] divisor,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        rx_frame_err,
  output logic        rx_overrun,
  output logic        rx_busy
);

  logic        rx1;
  logic        rx2;
  logic        tick;
  uart_state_t state;
  uart_state_t state_nxt;
  logic [3:0]  count16;
  logic [2:0]  bitcount;
  logic [7:0]  shreg;
  logic        s_first;
  logic        s_mid;
  logic        maj;
  logic        at_sample;
  logic        at_end;
  logic        load_byte;
  logic        frame_err_set;

  mmuart_baud_tick u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .divisor (divisor),
    .tick    (tick)
  );

  // Idle-high synchronizer so reset never looks like a start bit
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx1 <= 1'b1;
      rx2 <= 1'b1;
    end else begin
      rx1 <= uart_rx;
      rx2 <= rx1;
    end
  end

  assign maj       = majority3(s_first, s_mid, rx2);
  assign at_sample = tick && (count16 == SAMPLE_LAST);
  assign at_end    = tick && (count16 == COUNT_LAST);
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_byte     = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (tick && !rx2) state_nxt = START;
      end
      START: begin
        if (at_sample && maj) begin
          state_nxt = IDLE;
        end else if (at_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (at_end && (bitcount == BIT_LAST)) state_nxt = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed
        if (at_sample) begin
          if (maj) begin
            load_byte = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_nxt     = BREAK;
          end
        end
      end
      BREAK: begin
        if (tick && rx2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      count16  <= 4'd0;
      bitcount <= 3'd0;
      shreg    <= 8'd0;
      s_first  <= 1'b1;
      s_mid    <= 1'b1;
    end else begin
      if (state == IDLE) begin
        // The detecting tick counts as sample 0 of the start bit
        if (tick && !rx2) count16 <= 4'd1;
      end else if (tick) begin
        count16 <= count16 + 4'd1;
      end

      if (state != IDLE && tick) begin
        if (count16 == SAMPLE_FIRST) s_first <= rx2;
        if (count16 == SAMPLE_MID)   s_mid   <= rx2;
      end

      if (state == START && at_end) bitcount <= 3'd0;
      if (state == DATA && at_end)  bitcount <= bitcount + 3'd1;

      if (state == DATA && at_sample) shreg <= {maj, shreg[7:1]};
    end
  end

  // Holding register: a new byte wins over a same-cycle ack
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_err_set;
      rx_overrun   <= 1'b0;
      if (load_byte) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ack;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mmuart_rx.md
# mmuart_rx

UART receiver for the mmuart serial path: recovers 8N1 frames from the asynchronous `uart_rx` pin using 16x oversampling with 3-sample majority voting, validates start and stop bits, and presents each byte through a valid/ack holding register. Sits beside the UART transmitter, shares the same `divisor` programming (baud = f_sys_clk / (16 × divisor)), and reports framing and overrun errors to the CSR layer.

## Interface
- No parameters. Frame format fixed: 1 start, 8 data LSB-first, 1 stop, no parity.
- `sys_clk` in 1: system clock; single clock domain.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `uart_rx` in 1: serial input, asynchronous to `sys_clk`, idle high.
- `divisor` in 16: oversample tick period in `sys_clk` cycles; 0 is illegal (behaves as 65536).
- `rx_data` out 8: last good byte; stable while `rx_valid`=1.
- `rx_valid` out 1: byte available; held until acknowledged.
- `rx_ack` in 1: consumer accepts `rx_data` on the edge where it is sampled high with `rx_valid`=1.
- `rx_frame_err` out 1: 1-cycle pulse, stop bit sampled low.
- `rx_overrun` out 1: 1-cycle pulse, a good byte overwrote an unacknowledged one.
- `rx_busy` out 1: high in any state except IDLE.

## Operation
- Synchronizer: two flops, `uart_rx` → `rx1` → `rx2`; all logic uses `rx2`. Both flops reset to 1.
- Tick generator: 16-bit down-counter, async reset to 0; `tick` = (counter == 0); on tick reload `divisor − 1`, else decrement. `divisor` changes take effect at the next reload.
- Bit timing: `count16` (4 bits) increments on each tick, wraps 15→0. Samples of `rx2` captured on ticks at counts 7, 8, 9; bit value = majority of the three, decided on the count-9 tick.
- FSM states:
  - IDLE: on a tick with `rx2`=0 → START, `count16` ← 1.
  - START: on count-9 decision, majority 1 → IDLE (false start, no flag); otherwise continue; on count-15 tick → DATA, `bitcount` ← 0.
  - DATA: on count 9, shift majority into `shreg` MSB (right shift, LSB first on line); on count 15, `bitcount`++; after bit 7 → STOP.
  - STOP: on count-9 decision: majority 1 → load `rx_data` ← `shreg`, set `rx_valid`, → IDLE; majority 0 → pulse `rx_frame_err`, discard byte, → BREAK.
  - BREAK: wait until a tick with `rx2`=1, then → IDLE. Holds off restart during line break.
- Holding register: `rx_valid` clears on `rx_ack`. Good byte with `rx_valid`=1 and `rx_ack`=0 → overwrite, `rx_valid` stays 1, pulse `rx_overrun`. Good byte in the same cycle as `rx_ack` → new byte loaded, `rx_valid` stays 1, no overrun.
- `rx_ack` with `rx_valid`=0 is ignored.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0, FSM=IDLE, `count16`=0, `bitcount`=0, tick counter=0.
- Reset mid-frame: immediate return to IDLE; partial byte discarded; no flags.
- Pin-to-detection: 2 cycles synchronizer + up to `divisor` cycles to the next tick.
- `rx_data`/`rx_valid` update 1 cycle after the stop-bit count-9 tick, i.e. ~9.5 bit periods after the start edge; the receiver returns to IDLE mid-stop-bit so back-to-back frames are accepted.
- Error pulses are exactly one `sys_clk` cycle, registered, coincident with the cycle `rx_valid` would have updated.
- Tolerated baud mismatch: ±3% (sample point must remain within counts 7–9 of the stop bit).

## Structure
- Package `mmuart_pkg`: FSM state enum (IDLE, START, DATA, STOP, BREAK), constants OVERSAMPLE=16, SAMPLE_FIRST=7, SAMPLE_MID=8, SAMPLE_LAST=9, DATA_BITS=8; shared with the transmitter.
- Sub-module `mmuart_baud_tick`: divisor down-counter producing `tick`; reused by the transmitter.

## Test plan
- `divisor`=4 (64 clocks/bit), send 0xA5 8N1 → one `rx_valid` with `rx_data`=0xA5, no error pulses; `rx_ack` clears `rx_valid` next cycle.
- Low glitch of 3 ticks (12 clocks) on idle line → stays/returns IDLE, no `rx_valid`, no `rx_frame_err`; a following 0x3C frame is received correctly.
- Send 0x3C with stop bit driven low, then line high → `rx_frame_err` pulse once, `rx_valid` stays 0, FSM passes through BREAK; next frame 0x81 received.
- Send 0x11 then 0x22 back-to-back without `rx_ack` → `rx_overrun` pulse on second, `rx_data`=0x22, `rx_valid`=1; repeat with `rx_ack` asserted in the completion cycle → no overrun.
- Hold `uart_rx` low 20 bit periods → single `rx_frame_err`, `rx_busy` high until line returns high, then IDLE.
- Assert `sys_rst` during data bit 4 of 0xF0 → all outputs 0 immediately; after release, a full 0x5A frame is received correctly.
